// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: chain of STAGES elastic register slices carrying a
// payload and a control field. Each slice has a 2-entry skid buffer and a
// registered ready, so the chain sustains one entry per cycle. Bubbles carry
// a zero control field so write-enable bits never fire on invalid slots.
// Optional feature macro: PIPE_STATS_EN adds a saturating stall counter port.
module pipe_stage_elastic #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 3,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STATS_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } slice_state_t;

  // Link k is the input side of slice k; link STAGES is the block output.
  logic              link_v_s [STAGES+1];
  logic              link_r_s [STAGES+1];
  logic [DATA_W-1:0] link_d_s [STAGES+1];
  logic [CTRL_W-1:0] link_c_s [STAGES+1];

  assign link_v_s[0]      = in_valid;
  assign link_d_s[0]      = in_data;
  assign link_c_s[0]      = in_ctrl;
  assign link_r_s[STAGES] = out_ready;

  assign in_ready  = link_r_s[0];
  assign out_valid = link_v_s[STAGES];
  assign out_data  = link_d_s[STAGES];
  assign out_ctrl  = link_c_s[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    slice_state_t      state_r;
    logic              main_v_r;
    logic              rdy_r;
    logic [DATA_W-1:0] main_d_r;
    logic [CTRL_W-1:0] main_c_r;
    logic [DATA_W-1:0] skid_d_r;
    logic [CTRL_W-1:0] skid_c_r;
    logic              acc_s;
    logic              take_s;

    assign acc_s  = link_v_s[k] & rdy_r;
    assign take_s = main_v_r & link_r_s[k+1];

    assign link_v_s[k+1] = main_v_r;
    assign link_d_s[k+1] = main_d_r;
    assign link_c_s[k+1] = main_c_r;
    assign link_r_s[k]   = rdy_r;

    // Slice state machine: main/skid occupancy, registered ready, zeroed ctrl on bubbles.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r  <= EMPTY;
        main_v_r <= 1'b0;
        rdy_r    <= 1'b1;
        main_d_r <= '0;
        main_c_r <= '0;
        skid_d_r <= '0;
        skid_c_r <= '0;
      end else if (flush) begin
        // Data holds its last value; only validity and ctrl are cleared.
        state_r  <= EMPTY;
        main_v_r <= 1'b0;
        rdy_r    <= 1'b1;
        main_c_r <= '0;
      end else begin
        case (state_r)
          EMPTY: begin
            if (acc_s) begin
              state_r  <= ONE;
              main_v_r <= 1'b1;
              main_d_r <= link_d_s[k];
              main_c_r <= link_c_s[k];
            end
          end
          ONE: begin
            if (take_s && acc_s) begin
              main_d_r <= link_d_s[k];
              main_c_r <= link_c_s[k];
            end else if (take_s) begin
              state_r  <= EMPTY;
              main_v_r <= 1'b0;
              main_c_r <= '0;
            end else if (acc_s) begin
              state_r  <= FULL;
              rdy_r    <= 1'b0;
              skid_d_r <= link_d_s[k];
              skid_c_r <= link_c_s[k];
            end
          end
          FULL: begin
            // Ready is low here, so only the drain needs handling.
            if (take_s) begin
              state_r  <= ONE;
              rdy_r    <= 1'b1;
              main_d_r <= skid_d_r;
              main_c_r <= skid_c_r;
            end
          end
          default: begin
            state_r  <= EMPTY;
            main_v_r <= 1'b0;
            rdy_r    <= 1'b1;
            main_c_r <= '0;
          end
        endcase
      end
    end
  end

`ifdef PIPE_STATS_EN
  logic [31:0] stall_cnt_r;

  // Count cycles where upstream offers an entry the block cannot take; saturate at max.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 32'd0;
    end else if (in_valid && !in_ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: three instances (STAGES=1,2,3)
// sharing clock and reset, each driven by its own stimulus signals.
module tb_pipe_stage_elastic;

  localparam int DW = 101;
  localparam int CW = 3;

  logic          clk;
  logic          rst;
  logic          flush     [3];
  logic          in_valid  [3];
  logic          in_ready  [3];
  logic [DW-1:0] in_data   [3];
  logic [CW-1:0] in_ctrl   [3];
  logic          out_valid [3];
  logic          out_ready [3];
  logic [DW-1:0] out_data  [3];
  logic [CW-1:0] out_ctrl  [3];
`ifdef PIPE_STATS_EN
  logic [31:0]   stall_cnt [3];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_ctrl(in_ctrl[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_ctrl(out_ctrl[0])
`ifdef PIPE_STATS_EN
    , .stall_cnt(stall_cnt[0])
`endif
  );

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .STAGES(2)) u_s2 (
    .clk(clk), .rst(rst), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_ctrl(in_ctrl[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_ctrl(out_ctrl[1])
`ifdef PIPE_STATS_EN
    , .stall_cnt(stall_cnt[1])
`endif
  );

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .STAGES(3)) u_s3 (
    .clk(clk), .rst(rst), .flush(flush[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .in_ctrl(in_ctrl[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .out_ctrl(out_ctrl[2])
`ifdef PIPE_STATS_EN
    , .stall_cnt(stall_cnt[2])
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      flush[i]     = 1'b0;
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      in_ctrl[i]   = '0;
      out_ready[i] = 1'b0;
    end

    // Reset held while an entry is offered: nothing gets through.
    in_valid[0]  = 1'b1;
    in_data[0]   = 101'h1;
    in_ctrl[0]   = 3'b101;
    out_ready[0] = 1'b1;
    tick();
    tick();
    check("rst_out_valid", 128'(out_valid[0]), 128'd0);
    check("rst_out_ctrl",  128'(out_ctrl[0]),  128'd0);
    check("rst_out_data",  128'(out_data[0]),  128'd0);
    check("rst_in_ready",  128'(in_ready[0]),  128'd1);
    check("rst_s3_ready",  128'(in_ready[2]),  128'd1);

    // Single entry through STAGES=1.
    rst = 1'b0;
    tick();
    check("s1_valid", 128'(out_valid[0]), 128'd1);
    check("s1_data",  128'(out_data[0]),  128'h1);
    check("s1_ctrl",  128'(out_ctrl[0]),  128'h5);
    in_valid[0] = 1'b0;
    tick();
    check("s1_bubble_valid", 128'(out_valid[0]), 128'd0);
    check("s1_bubble_ctrl",  128'(out_ctrl[0]),  128'd0);
    check("s1_bubble_data",  128'(out_data[0]),  128'h1);

    // STAGES=2 streaming 1..8, two-cycle latency, no stalls.
    out_ready[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        check("s2_in_ready", 128'(in_ready[1]), 128'd1);
        in_valid[1] = 1'b1;
        in_data[1]  = DW'(c + 1);
        in_ctrl[1]  = 3'b011;
      end else begin
        in_valid[1] = 1'b0;
      end
      tick();
      if (c == 0 || c == 9) begin
        check("s2_idle_valid", 128'(out_valid[1]), 128'd0);
      end else begin
        check("s2_stream_valid", 128'(out_valid[1]), 128'd1);
        check("s2_stream_data",  128'(out_data[1]),  128'(c));
      end
    end

    // STAGES=1 backpressure: fill main and skid, third entry waits.
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_ctrl[0]   = 3'b001;
    in_data[0]   = 101'h11;
    check("bp_ready0", 128'(in_ready[0]), 128'd1);
    tick();
    in_data[0] = 101'h22;
    check("bp_ready1", 128'(in_ready[0]), 128'd1);
    tick();
    in_data[0] = 101'h33;
    check("bp_full_ready", 128'(in_ready[0]), 128'd0);
    check("bp_hold_data",  128'(out_data[0]), 128'h11);
    tick();
    check("bp_full_ready2", 128'(in_ready[0]), 128'd0);
    check("bp_hold_data2",  128'(out_data[0]), 128'h11);
    check("bp_hold_valid",  128'(out_valid[0]), 128'd1);
    out_ready[0] = 1'b1;
    tick();
    check("bp_drain_data1",  128'(out_data[0]), 128'h22);
    check("bp_drain_ready",  128'(in_ready[0]), 128'd1);
    tick();
    check("bp_drain_valid2", 128'(out_valid[0]), 128'd1);
    check("bp_drain_data2",  128'(out_data[0]),  128'h33);
    in_valid[0] = 1'b0;
    tick();
    check("bp_empty_valid", 128'(out_valid[0]), 128'd0);

    // STAGES=3 flush with a simultaneous input.
    out_ready[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("fl_load_ready", 128'(in_ready[2]), 128'd1);
      in_valid[2] = 1'b1;
      in_data[2]  = DW'(8'hA0 + i);
      in_ctrl[2]  = 3'b110;
      tick();
    end
    check("fl_pre_valid", 128'(out_valid[2]), 128'd1);
    check("fl_pre_data",  128'(out_data[2]),  128'hA0);
    flush[2]    = 1'b1;
    in_data[2]  = 101'hEE;
    in_ctrl[2]  = 3'b111;
    tick();
    flush[2]     = 1'b0;
    in_valid[2]  = 1'b0;
    out_ready[2] = 1'b1;
    check("fl_valid", 128'(out_valid[2]), 128'd0);
    check("fl_ctrl",  128'(out_ctrl[2]),  128'd0);
    check("fl_ready", 128'(in_ready[2]),  128'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("fl_no_ghost", 128'(out_valid[2]), 128'd0);
    end

    // Reset while FULL and blocked on STAGES=1.
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_data[0]   = 101'h44;
    tick();
    in_data[0] = 101'h55;
    tick();
    in_valid[0] = 1'b0;
    check("rf_full_ready", 128'(in_ready[0]), 128'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rf_valid", 128'(out_valid[0]), 128'd0);
    check("rf_ready", 128'(in_ready[0]),  128'd1);
    check("rf_data",  128'(out_data[0]),  128'd0);
    out_ready[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rf_no_stale", 128'(out_valid[0]), 128'd0);
    end

`ifdef PIPE_STATS_EN
    // Stall counter: 10 offered cycles, 2 accepted, 8 stalled.
    check("st_reset", 128'(stall_cnt[0]), 128'd0);
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
    end
    in_valid[0] = 1'b0;
    tick();
    check("st_count", 128'(stall_cnt[0]), 128'd8);
    flush[0] = 1'b1;
    tick();
    flush[0] = 1'b0;
    check("st_flush_keep", 128'(stall_cnt[0]), 128'd8);
    check("st_flush_ready", 128'(in_ready[0]), 128'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("st_rst_clear", 128'(stall_cnt[0]), 128'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised, elastic pipeline register for the RV32i core, generalising the fixed MEM/WB register.
- Carries an opaque data payload and a control field through STAGES register slices.
- Each slice has a valid/ready handshake and a 2-entry skid buffer, giving full throughput with registered ready.
- Adds flush (bubble injection) and forces the control field to zero on bubbles, so RegWrite-type bits never fire on invalid slots.

Parameters:
- DATA_W, 101, payload width (e.g. ALUResult+ReadData+PCPlus4+Rd = 32+32+32+5).
- CTRL_W, 3, control-field width (e.g. RegWrite+ResultSrc); legal range 1..32.
- STAGES, 1, number of chained slices; legal range 1..4.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- flush  input  1  discard all in-flight entries
- in_valid  input  1  upstream entry present
- in_ready  output  1  block can accept this cycle
- in_data  input  DATA_W  upstream payload
- in_ctrl  input  CTRL_W  upstream control bits
- out_valid  output  1  downstream entry present
- out_ready  input  1  downstream consumes this cycle
- out_data  output  DATA_W  payload of head entry
- out_ctrl  output  CTRL_W  control bits of head entry; zero when out_valid=0
- stall_cnt  output  32  saturating stall counter (present only with PIPE_STATS_EN)

Behaviour:
- Transfer definitions: accept = in_valid & in_ready; take = out_valid & out_ready. Slice k's output feeds slice k+1's input.
- Each slice holds a main register (drives the slice output) and a skid register. Slice states:
  - EMPTY: main and skid both invalid.
  - ONE: main valid, skid invalid.
  - FULL: main and skid both valid.
- Slice in_ready is registered: 1 unless the slice is FULL.
- EMPTY: accept -> ONE, main loads input. No accept -> stay EMPTY.
- ONE:
  - take & accept -> ONE, main loads input.
  - take & !accept -> EMPTY.
  - !take & accept -> FULL, skid loads input.
  - !take & !accept -> stay ONE.
- FULL: no accept is possible (in_ready=0). take -> ONE, main loads skid. !take -> stay FULL.
- Latency and throughput: STAGES cycles from accept to out_valid when unblocked; sustained 1 entry/cycle. Ordering is strictly FIFO.
- Data/ctrl integrity: out_data and out_ctrl must not change while out_valid=1 and out_ready=0.
- out_ctrl is forced to 0 whenever out_valid=0. out_data holds its last value when invalid.
- Reset (rst=1 at an edge):
  - All slices go EMPTY.
  - out_valid=0, out_data=0, out_ctrl=0, in_ready=1 from the next cycle.
  - stall_cnt=0.
  - Reset mid-transfer discards all entries, with no partial output.
- Flush (flush=1 at an edge):
  - All slices go EMPTY.
  - An input presented in the same cycle is discarded even if in_valid=in_ready=1.
  - out_valid=0 and in_ready=1 the next cycle.
  - Priority: rst > flush > normal.
- Simultaneous events:
  - A take and an accept in the same cycle on a ONE slice is a pass-through replace, with no bubble.
  - A FULL slice draining while upstream is valid does not accept until the next cycle (registered ready).
- Capacity: 2*STAGES entries total.

Optional Feature:
- Macro: PIPE_STATS_EN.
- Defined:
  - stall_cnt port exists.
  - Increments by 1 each cycle with in_valid=1 and in_ready=0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by rst; not cleared by flush.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- STAGES=1: reset, then in_valid=1 with in_data=0x1, in_ctrl=3'b101, out_ready=1 -> next cycle out_valid=1, out_data=0x1, out_ctrl=3'b101; with rst held, out_ctrl=0 and out_valid=0.
- STAGES=2, out_ready=1: stream in_data 1..8 back-to-back -> out_data 1..8 on consecutive cycles starting 2 cycles after the first accept; in_ready stays 1.
- STAGES=1: hold out_ready=0 and offer 3 entries -> two accepted (ONE, then FULL), in_ready=0 from the cycle after the 2nd accept; out_data stable at entry 1. Release out_ready -> entries 1, 2 emerge in order, then entry 3 is accepted.
- STAGES=3: load 4 entries, assert flush for 1 cycle together with in_valid=1 -> next cycle out_valid=0 and out_ctrl=0; the flushed-cycle input never appears; in_ready=1.
- With PIPE_STATS_EN: out_ready=0, in_valid=1 for 10 cycles with STAGES=1 -> stall_cnt=8; then flush -> stall_cnt unchanged; then rst -> stall_cnt=0.
- Reset asserted while FULL and out_ready=0 -> next cycle out_valid=0, in_ready=1, out_data=0; no stale entry is emitted after reset deasserts.
